// File: rtl/client_tile_link_network_port.sv
// Client-side TileLink network endpoint: adds/strips network headers and acts as the finish
// unit, queueing one finish per grant that needs acknowledgement.
module client_tile_link_network_port #(
    parameter int unsigned CLIENT_ID    = 0,
    parameter int unsigned MANAGER_ID   = 1,
    parameter int unsigned FINISH_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    // client acquire
    output logic        io_client_acquire_ready,
    input  logic        io_client_acquire_valid,
    input  logic [25:0] io_client_acquire_bits_addr_block,
    input  logic        io_client_acquire_bits_client_xact_id,
    input  logic [2:0]  io_client_acquire_bits_addr_beat,
    input  logic        io_client_acquire_bits_is_builtin_type,
    input  logic [2:0]  io_client_acquire_bits_a_type,
    input  logic [11:0] io_client_acquire_bits_union,
    input  logic [63:0] io_client_acquire_bits_data,
    // client release
    output logic        io_client_release_ready,
    input  logic        io_client_release_valid,
    input  logic [2:0]  io_client_release_bits_addr_beat,
    input  logic [25:0] io_client_release_bits_addr_block,
    input  logic        io_client_release_bits_client_xact_id,
    input  logic        io_client_release_bits_voluntary,
    input  logic [2:0]  io_client_release_bits_r_type,
    input  logic [63:0] io_client_release_bits_data,
    // client grant
    input  logic        io_client_grant_ready,
    output logic        io_client_grant_valid,
    output logic [2:0]  io_client_grant_bits_addr_beat,
    output logic        io_client_grant_bits_client_xact_id,
    output logic [1:0]  io_client_grant_bits_manager_xact_id,
    output logic        io_client_grant_bits_is_builtin_type,
    output logic [3:0]  io_client_grant_bits_g_type,
    output logic [63:0] io_client_grant_bits_data,
    // client probe
    input  logic        io_client_probe_ready,
    output logic        io_client_probe_valid,
    output logic [25:0] io_client_probe_bits_addr_block,
    output logic [1:0]  io_client_probe_bits_p_type,
    // network acquire
    input  logic        io_network_acquire_ready,
    output logic        io_network_acquire_valid,
    output logic [1:0]  io_network_acquire_bits_header_src,
    output logic [1:0]  io_network_acquire_bits_header_dst,
    output logic [25:0] io_network_acquire_bits_payload_addr_block,
    output logic        io_network_acquire_bits_payload_client_xact_id,
    output logic [2:0]  io_network_acquire_bits_payload_addr_beat,
    output logic        io_network_acquire_bits_payload_is_builtin_type,
    output logic [2:0]  io_network_acquire_bits_payload_a_type,
    output logic [11:0] io_network_acquire_bits_payload_union,
    output logic [63:0] io_network_acquire_bits_payload_data,
    // network release
    input  logic        io_network_release_ready,
    output logic        io_network_release_valid,
    output logic [1:0]  io_network_release_bits_header_src,
    output logic [1:0]  io_network_release_bits_header_dst,
    output logic [2:0]  io_network_release_bits_payload_addr_beat,
    output logic [25:0] io_network_release_bits_payload_addr_block,
    output logic        io_network_release_bits_payload_client_xact_id,
    output logic        io_network_release_bits_payload_voluntary,
    output logic [2:0]  io_network_release_bits_payload_r_type,
    output logic [63:0] io_network_release_bits_payload_data,
    // network grant
    output logic        io_network_grant_ready,
    input  logic        io_network_grant_valid,
    input  logic [1:0]  io_network_grant_bits_header_src,
    input  logic [1:0]  io_network_grant_bits_header_dst,
    input  logic [2:0]  io_network_grant_bits_payload_addr_beat,
    input  logic        io_network_grant_bits_payload_client_xact_id,
    input  logic [1:0]  io_network_grant_bits_payload_manager_xact_id,
    input  logic        io_network_grant_bits_payload_is_builtin_type,
    input  logic [3:0]  io_network_grant_bits_payload_g_type,
    input  logic [63:0] io_network_grant_bits_payload_data,
    // network probe
    output logic        io_network_probe_ready,
    input  logic        io_network_probe_valid,
    input  logic [1:0]  io_network_probe_bits_header_src,
    input  logic [1:0]  io_network_probe_bits_header_dst,
    input  logic [25:0] io_network_probe_bits_payload_addr_block,
    input  logic [1:0]  io_network_probe_bits_payload_p_type,
    // network finish
    input  logic        io_network_finish_ready,
    output logic        io_network_finish_valid,
    output logic [1:0]  io_network_finish_bits_header_src,
    output logic [1:0]  io_network_finish_bits_header_dst,
    output logic [1:0]  io_network_finish_bits_payload_manager_xact_id
);

    localparam int unsigned PtrW = (FINISH_DEPTH > 1) ? $clog2(FINISH_DEPTH) : 1;
    localparam int unsigned CntW = $clog2(FINISH_DEPTH + 1);
    localparam logic [CntW-1:0] CntFull = CntW'(FINISH_DEPTH);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(FINISH_DEPTH - 1);
    localparam logic [1:0] SrcId = 2'(CLIENT_ID);
    localparam logic [1:0] DstId = 2'(MANAGER_ID);

    logic [PtrW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0] count_q, count_d;
    logic [1:0]      fin_dst_q [FINISH_DEPTH];
    logic [1:0]      fin_xid_q [FINISH_DEPTH];

    logic voluntary, multibeat, needs_finish, full, block, grant_fire, enq, deq;

    // Acquire / release: pass-through with header insertion
    assign io_client_acquire_ready = io_network_acquire_ready;
    assign io_network_acquire_valid = io_client_acquire_valid;
    assign io_network_acquire_bits_header_src = SrcId;
    assign io_network_acquire_bits_header_dst = DstId;
    assign io_network_acquire_bits_payload_addr_block = io_client_acquire_bits_addr_block;
    assign io_network_acquire_bits_payload_client_xact_id = io_client_acquire_bits_client_xact_id;
    assign io_network_acquire_bits_payload_addr_beat = io_client_acquire_bits_addr_beat;
    assign io_network_acquire_bits_payload_is_builtin_type = io_client_acquire_bits_is_builtin_type;
    assign io_network_acquire_bits_payload_a_type = io_client_acquire_bits_a_type;
    assign io_network_acquire_bits_payload_union = io_client_acquire_bits_union;
    assign io_network_acquire_bits_payload_data = io_client_acquire_bits_data;

    assign io_client_release_ready = io_network_release_ready;
    assign io_network_release_valid = io_client_release_valid;
    assign io_network_release_bits_header_src = SrcId;
    assign io_network_release_bits_header_dst = DstId;
    assign io_network_release_bits_payload_addr_beat = io_client_release_bits_addr_beat;
    assign io_network_release_bits_payload_addr_block = io_client_release_bits_addr_block;
    assign io_network_release_bits_payload_client_xact_id = io_client_release_bits_client_xact_id;
    assign io_network_release_bits_payload_voluntary = io_client_release_bits_voluntary;
    assign io_network_release_bits_payload_r_type = io_client_release_bits_r_type;
    assign io_network_release_bits_payload_data = io_client_release_bits_data;

    assign io_network_probe_ready = io_client_probe_ready;
    assign io_client_probe_valid = io_network_probe_valid;
    assign io_client_probe_bits_addr_block = io_network_probe_bits_payload_addr_block;
    assign io_client_probe_bits_p_type = io_network_probe_bits_payload_p_type;

    // Only the last beat of a multibeat grant can need a finish, so earlier beats never stall
    assign voluntary = io_network_grant_bits_payload_is_builtin_type &&
                       (io_network_grant_bits_payload_g_type == 4'd0);
    assign multibeat = (io_network_grant_bits_payload_is_builtin_type &&
                        (io_network_grant_bits_payload_g_type == 4'd4)) ||
                       (!io_network_grant_bits_payload_is_builtin_type &&
                        (io_network_grant_bits_payload_g_type <= 4'd1));
    assign needs_finish = !voluntary &&
                          (!multibeat || (io_network_grant_bits_payload_addr_beat == 3'd7));

    // Reset forces the queue to look empty so gating and finish_valid ignore stale state
    assign full  = !reset && (count_q == CntFull);
    assign block = needs_finish && full;

    assign io_client_grant_valid = io_network_grant_valid && !block;
    assign io_network_grant_ready = io_client_grant_ready && !block;
    assign io_client_grant_bits_addr_beat = io_network_grant_bits_payload_addr_beat;
    assign io_client_grant_bits_client_xact_id = io_network_grant_bits_payload_client_xact_id;
    assign io_client_grant_bits_manager_xact_id = io_network_grant_bits_payload_manager_xact_id;
    assign io_client_grant_bits_is_builtin_type = io_network_grant_bits_payload_is_builtin_type;
    assign io_client_grant_bits_g_type = io_network_grant_bits_payload_g_type;
    assign io_client_grant_bits_data = io_network_grant_bits_payload_data;

    assign io_network_finish_valid = !reset && (count_q != '0);
    assign io_network_finish_bits_header_src = SrcId;
    assign io_network_finish_bits_header_dst = fin_dst_q[head_q];
    assign io_network_finish_bits_payload_manager_xact_id = fin_xid_q[head_q];

    assign grant_fire = io_network_grant_valid && io_network_grant_ready;
    assign enq = grant_fire && needs_finish && !reset;
    assign deq = io_network_finish_valid && io_network_finish_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) head_d = (head_q == PtrLast) ? '0 : head_q + 1'b1;
        if (enq) tail_d = (tail_q == PtrLast) ? '0 : tail_q + 1'b1;
        unique case ({enq, deq})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fin_dst_q[tail_q] <= io_network_grant_bits_header_src;
            fin_xid_q[tail_q] <= io_network_grant_bits_payload_manager_xact_id;
        end
    end

endmodule

// File: tb/tb_client_tile_link_network_port.sv
// Self-checking bench: directed scenarios with a finish scoreboard filled on grant acceptance
// and drained as finishes leave the port.
module tb_client_tile_link_network_port;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        c_acq_ready, c_acq_valid, c_acq_xid, c_acq_builtin;
    logic [25:0] c_acq_block;
    logic [2:0]  c_acq_beat, c_acq_type;
    logic [11:0] c_acq_union;
    logic [63:0] c_acq_data;
    logic        c_rel_ready, c_rel_valid, c_rel_xid, c_rel_vol;
    logic [2:0]  c_rel_beat, c_rel_type;
    logic [25:0] c_rel_block;
    logic [63:0] c_rel_data;
    logic        c_gnt_ready, c_gnt_valid, c_gnt_xid, c_gnt_builtin;
    logic [2:0]  c_gnt_beat;
    logic [1:0]  c_gnt_mxid;
    logic [3:0]  c_gnt_type;
    logic [63:0] c_gnt_data;
    logic        c_prb_ready, c_prb_valid;
    logic [25:0] c_prb_block;
    logic [1:0]  c_prb_type;
    logic        n_acq_ready, n_acq_valid, n_acq_xid, n_acq_builtin;
    logic [1:0]  n_acq_src, n_acq_dst;
    logic [25:0] n_acq_block;
    logic [2:0]  n_acq_beat, n_acq_type;
    logic [11:0] n_acq_union;
    logic [63:0] n_acq_data;
    logic        n_rel_ready, n_rel_valid, n_rel_xid, n_rel_vol;
    logic [1:0]  n_rel_src, n_rel_dst;
    logic [2:0]  n_rel_beat, n_rel_type;
    logic [25:0] n_rel_block;
    logic [63:0] n_rel_data;
    logic        n_gnt_ready, n_gnt_valid, n_gnt_xid, n_gnt_builtin;
    logic [1:0]  n_gnt_src, n_gnt_dst, n_gnt_mxid;
    logic [2:0]  n_gnt_beat;
    logic [3:0]  n_gnt_type;
    logic [63:0] n_gnt_data;
    logic        n_prb_ready, n_prb_valid;
    logic [1:0]  n_prb_src, n_prb_dst, n_prb_type;
    logic [25:0] n_prb_block;
    logic        n_fin_ready, n_fin_valid;
    logic [1:0]  n_fin_src, n_fin_dst, n_fin_mxid;

    int checks = 0;
    int errors = 0;
    logic       exp_fin;
    logic [3:0] sb [$];

    client_tile_link_network_port #(.CLIENT_ID(0), .MANAGER_ID(1), .FINISH_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .io_client_acquire_ready(c_acq_ready), .io_client_acquire_valid(c_acq_valid),
        .io_client_acquire_bits_addr_block(c_acq_block),
        .io_client_acquire_bits_client_xact_id(c_acq_xid),
        .io_client_acquire_bits_addr_beat(c_acq_beat),
        .io_client_acquire_bits_is_builtin_type(c_acq_builtin),
        .io_client_acquire_bits_a_type(c_acq_type), .io_client_acquire_bits_union(c_acq_union),
        .io_client_acquire_bits_data(c_acq_data),
        .io_client_release_ready(c_rel_ready), .io_client_release_valid(c_rel_valid),
        .io_client_release_bits_addr_beat(c_rel_beat),
        .io_client_release_bits_addr_block(c_rel_block),
        .io_client_release_bits_client_xact_id(c_rel_xid),
        .io_client_release_bits_voluntary(c_rel_vol), .io_client_release_bits_r_type(c_rel_type),
        .io_client_release_bits_data(c_rel_data),
        .io_client_grant_ready(c_gnt_ready), .io_client_grant_valid(c_gnt_valid),
        .io_client_grant_bits_addr_beat(c_gnt_beat),
        .io_client_grant_bits_client_xact_id(c_gnt_xid),
        .io_client_grant_bits_manager_xact_id(c_gnt_mxid),
        .io_client_grant_bits_is_builtin_type(c_gnt_builtin),
        .io_client_grant_bits_g_type(c_gnt_type), .io_client_grant_bits_data(c_gnt_data),
        .io_client_probe_ready(c_prb_ready), .io_client_probe_valid(c_prb_valid),
        .io_client_probe_bits_addr_block(c_prb_block), .io_client_probe_bits_p_type(c_prb_type),
        .io_network_acquire_ready(n_acq_ready), .io_network_acquire_valid(n_acq_valid),
        .io_network_acquire_bits_header_src(n_acq_src),
        .io_network_acquire_bits_header_dst(n_acq_dst),
        .io_network_acquire_bits_payload_addr_block(n_acq_block),
        .io_network_acquire_bits_payload_client_xact_id(n_acq_xid),
        .io_network_acquire_bits_payload_addr_beat(n_acq_beat),
        .io_network_acquire_bits_payload_is_builtin_type(n_acq_builtin),
        .io_network_acquire_bits_payload_a_type(n_acq_type),
        .io_network_acquire_bits_payload_union(n_acq_union),
        .io_network_acquire_bits_payload_data(n_acq_data),
        .io_network_release_ready(n_rel_ready), .io_network_release_valid(n_rel_valid),
        .io_network_release_bits_header_src(n_rel_src),
        .io_network_release_bits_header_dst(n_rel_dst),
        .io_network_release_bits_payload_addr_beat(n_rel_beat),
        .io_network_release_bits_payload_addr_block(n_rel_block),
        .io_network_release_bits_payload_client_xact_id(n_rel_xid),
        .io_network_release_bits_payload_voluntary(n_rel_vol),
        .io_network_release_bits_payload_r_type(n_rel_type),
        .io_network_release_bits_payload_data(n_rel_data),
        .io_network_grant_ready(n_gnt_ready), .io_network_grant_valid(n_gnt_valid),
        .io_network_grant_bits_header_src(n_gnt_src),
        .io_network_grant_bits_header_dst(n_gnt_dst),
        .io_network_grant_bits_payload_addr_beat(n_gnt_beat),
        .io_network_grant_bits_payload_client_xact_id(n_gnt_xid),
        .io_network_grant_bits_payload_manager_xact_id(n_gnt_mxid),
        .io_network_grant_bits_payload_is_builtin_type(n_gnt_builtin),
        .io_network_grant_bits_payload_g_type(n_gnt_type),
        .io_network_grant_bits_payload_data(n_gnt_data),
        .io_network_probe_ready(n_prb_ready), .io_network_probe_valid(n_prb_valid),
        .io_network_probe_bits_header_src(n_prb_src),
        .io_network_probe_bits_header_dst(n_prb_dst),
        .io_network_probe_bits_payload_addr_block(n_prb_block),
        .io_network_probe_bits_payload_p_type(n_prb_type),
        .io_network_finish_ready(n_fin_ready), .io_network_finish_valid(n_fin_valid),
        .io_network_finish_bits_header_src(n_fin_src),
        .io_network_finish_bits_header_dst(n_fin_dst),
        .io_network_finish_bits_payload_manager_xact_id(n_fin_mxid)
    );

    // Inputs change on the falling edge; fires are recorded just after, well before the rising edge
    task automatic tick();
        logic [3:0] exp;
        #1;
        if (n_gnt_valid && n_gnt_ready && exp_fin) sb.push_back({n_gnt_src, n_gnt_mxid});
        if (n_fin_valid && n_fin_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL finish_unexpected got dst=%0d xid=%0d expected none",
                         n_fin_dst, n_fin_mxid);
            end else begin
                exp = sb.pop_front();
                if ({n_fin_src, n_fin_dst, n_fin_mxid} !== {2'd0, exp}) begin
                    errors++;
                    $display("FAIL finish_order got src=%0d dst=%0d xid=%0d expected 0/%0d/%0d",
                             n_fin_src, n_fin_dst, n_fin_mxid, exp[3:2], exp[1:0]);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic drive_grant(input logic v, input logic bi, input logic [3:0] gt,
                               input logic [2:0] beat, input logic [1:0] mx,
                               input logic [1:0] src, input logic ef);
        n_gnt_valid = v; n_gnt_builtin = bi; n_gnt_type = gt; n_gnt_beat = beat;
        n_gnt_mxid = mx; n_gnt_src = src; exp_fin = ef;
        n_gnt_data = {32'hC0DE0000, 29'd0, beat}; n_gnt_xid = beat[0];
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_grant(1'b1, 1'b1, 4'd2, 3'd0, 2'd1, 2'd2, 1'b0);
        #1;
        checks++;
        if (n_fin_valid !== 1'b0 || n_gnt_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cycle got fin_valid=%b gnt_ready=%b expected 0/1",
                     n_fin_valid, n_gnt_ready);
        end
        tick(); tick();
        reset = 1'b0;
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if (n_fin_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got fin_valid=%b expected 0", n_fin_valid);
        end
        tick();
    endtask

    task automatic test_acquire_release();
        c_acq_valid = 1'b1; c_acq_block = 26'h155AA; c_acq_type = 3'h2; c_acq_xid = 1'b1;
        c_acq_beat = 3'd5; c_acq_builtin = 1'b1; c_acq_union = 12'hA5C;
        c_acq_data = 64'h0123456789ABCDEF; n_acq_ready = 1'b1;
        c_rel_valid = 1'b1; c_rel_block = 26'h2AA55; c_rel_type = 3'h6; c_rel_xid = 1'b0;
        c_rel_beat = 3'd3; c_rel_vol = 1'b1; c_rel_data = 64'hFEDCBA9876543210;
        n_rel_ready = 1'b0;
        #1;
        checks++;
        if ({n_acq_valid, n_acq_src, n_acq_dst, c_acq_ready} !== {1'b1, 2'd0, 2'd1, 1'b1} ||
            {n_acq_block, n_acq_type, n_acq_xid, n_acq_beat, n_acq_builtin, n_acq_union,
             n_acq_data} !== {26'h155AA, 3'h2, 1'b1, 3'd5, 1'b1, 12'hA5C, 64'h0123456789ABCDEF})
        begin
            errors++;
            $display("FAIL acquire got v=%b src=%0d dst=%0d rdy=%b blk=%h type=%h expected 1/0/1/1/155aa/2",
                     n_acq_valid, n_acq_src, n_acq_dst, c_acq_ready, n_acq_block, n_acq_type);
        end
        checks++;
        if ({n_rel_valid, n_rel_src, n_rel_dst, c_rel_ready} !== {1'b1, 2'd0, 2'd1, 1'b0} ||
            {n_rel_block, n_rel_type, n_rel_xid, n_rel_beat, n_rel_vol, n_rel_data} !==
            {26'h2AA55, 3'h6, 1'b0, 3'd3, 1'b1, 64'hFEDCBA9876543210}) begin
            errors++;
            $display("FAIL release got v=%b src=%0d dst=%0d rdy=%b blk=%h expected 1/0/1/0/2aa55",
                     n_rel_valid, n_rel_src, n_rel_dst, c_rel_ready, n_rel_block);
        end
        n_acq_ready = 1'b0; n_rel_ready = 1'b1; c_acq_valid = 1'b0;
        #1;
        checks++;
        if ({c_acq_ready, c_rel_ready, n_acq_valid} !== 3'b010) begin
            errors++;
            $display("FAIL ready_mirror got acq=%b rel=%b nav=%b expected 0/1/0",
                     c_acq_ready, c_rel_ready, n_acq_valid);
        end
        tick();
    endtask

    task automatic test_probe();
        n_prb_valid = 1'b1; n_prb_block = 26'h3FF00F; n_prb_type = 2'd2; n_prb_src = 2'd1;
        n_prb_dst = 2'd0; c_prb_ready = 1'b1;
        #1;
        checks++;
        if ({c_prb_valid, c_prb_block, c_prb_type, n_prb_ready} !== {1'b1, 26'h3FF00F, 2'd2, 1'b1})
        begin
            errors++;
            $display("FAIL probe got v=%b blk=%h type=%0d rdy=%b expected 1/3ff00f/2/1",
                     c_prb_valid, c_prb_block, c_prb_type, n_prb_ready);
        end
        n_prb_valid = 1'b0;
        tick();
    endtask

    task automatic test_put_ack();
        n_fin_ready = 1'b1;
        drive_grant(1'b1, 1'b1, 4'd2, 3'd0, 2'd3, 2'd1, 1'b1);
        #1;
        checks++;
        if ({c_gnt_valid, n_gnt_ready, c_gnt_mxid, c_gnt_type, c_gnt_builtin, n_fin_valid} !==
            {1'b1, 1'b1, 2'd3, 4'd2, 1'b1, 1'b0} || c_gnt_data !== n_gnt_data) begin
            errors++;
            $display("FAIL put_ack_grant got v=%b rdy=%b xid=%0d fin_valid=%b expected 1/1/3/0",
                     c_gnt_valid, n_gnt_ready, c_gnt_mxid, n_fin_valid);
        end
        tick();
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if ({n_fin_valid, n_fin_src, n_fin_dst, n_fin_mxid} !== {1'b1, 2'd0, 2'd1, 2'd3}) begin
            errors++;
            $display("FAIL put_ack_finish got v=%b src=%0d dst=%0d xid=%0d expected 1/0/1/3",
                     n_fin_valid, n_fin_src, n_fin_dst, n_fin_mxid);
        end
        tick();
        #1;
        checks++;
        if (n_fin_valid !== 1'b0) begin
            errors++;
            $display("FAIL put_ack_drain got fin_valid=%b expected 0", n_fin_valid);
        end
        tick();
    endtask

    task automatic test_multibeat();
        int beats;
        beats = 0;
        n_fin_ready = 1'b0;
        for (int b = 0; b < 8; b++) begin
            drive_grant(1'b1, 1'b1, 4'd4, 3'(b), 2'd2, 2'd3, b == 7);
            #1;
            if (c_gnt_valid && n_gnt_ready && c_gnt_beat == 3'(b) && !n_fin_valid) beats++;
            tick();
        end
        checks++;
        if (beats != 8) begin
            errors++;
            $display("FAIL multibeat_pass got %0d clean beats expected 8", beats);
        end
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if ({n_fin_valid, n_fin_dst, n_fin_mxid} !== {1'b1, 2'd3, 2'd2}) begin
            errors++;
            $display("FAIL multibeat_finish got v=%b dst=%0d xid=%0d expected 1/3/2",
                     n_fin_valid, n_fin_dst, n_fin_mxid);
        end
        n_fin_ready = 1'b1;
        tick();
        #1;
        checks++;
        if (n_fin_valid !== 1'b0) begin
            errors++;
            $display("FAIL multibeat_single got fin_valid=%b expected 0", n_fin_valid);
        end
        tick();
    endtask

    task automatic test_voluntary();
        drive_grant(1'b1, 1'b1, 4'd0, 3'd0, 2'd1, 2'd1, 1'b0);
        #1;
        checks++;
        if ({c_gnt_valid, n_gnt_ready} !== 2'b11) begin
            errors++;
            $display("FAIL voluntary_deliver got v=%b rdy=%b expected 1/1", c_gnt_valid, n_gnt_ready);
        end
        tick();
        // non-builtin multibeat, middle beat: no finish either
        drive_grant(1'b1, 1'b0, 4'd1, 3'd3, 2'd1, 2'd1, 1'b0);
        tick();
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if (n_fin_valid !== 1'b0) begin
            errors++;
            $display("FAIL voluntary_nofinish got fin_valid=%b expected 0", n_fin_valid);
        end
        tick();
    endtask

    task automatic test_full();
        n_fin_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_grant(1'b1, 1'b1, 4'd2, 3'd0, 2'(i), 2'(i + 1), 1'b1);
            #1;
            checks++;
            if (n_gnt_ready !== 1'b1) begin
                errors++;
                $display("FAIL full_accept%0d got rdy=%b expected 1", i, n_gnt_ready);
            end
            tick();
        end
        drive_grant(1'b1, 1'b1, 4'd2, 3'd0, 2'd2, 2'd3, 1'b1);
        #1;
        checks++;
        if ({n_gnt_ready, c_gnt_valid} !== 2'b00) begin
            errors++;
            $display("FAIL full_block got rdy=%b v=%b expected 0/0", n_gnt_ready, c_gnt_valid);
        end
        tick();
        n_fin_ready = 1'b1;
        #1;
        checks++;
        if ({n_gnt_ready, n_fin_valid} !== 2'b01) begin
            errors++;
            $display("FAIL full_nobypass got rdy=%b fin_valid=%b expected 0/1",
                     n_gnt_ready, n_fin_valid);
        end
        tick();
        #1;
        checks++;
        if ({n_gnt_ready, c_gnt_valid} !== 2'b11) begin
            errors++;
            $display("FAIL full_release got rdy=%b v=%b expected 1/1", n_gnt_ready, c_gnt_valid);
        end
        tick();
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        tick();
        #1;
        checks++;
        if (n_fin_valid !== 1'b0 || sb.size() != 0) begin
            errors++;
            $display("FAIL full_drain got fin_valid=%b pending=%0d expected 0/0",
                     n_fin_valid, sb.size());
        end
        tick();
    endtask

    task automatic test_reset_flush();
        n_fin_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive_grant(1'b1, 1'b1, 4'd2, 3'd0, 2'(i + 2), 2'(i), 1'b1);
            tick();
        end
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        reset = 1'b1;
        #1;
        checks++;
        if (n_fin_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_during got fin_valid=%b expected 0", n_fin_valid);
        end
        tick();
        sb.delete();
        reset = 1'b0;
        drive_grant(1'b1, 1'b1, 4'd2, 3'd0, 2'd1, 2'd2, 1'b1);
        #1;
        checks++;
        if ({n_fin_valid, n_gnt_ready} !== 2'b01) begin
            errors++;
            $display("FAIL flush_after got fin_valid=%b rdy=%b expected 0/1",
                     n_fin_valid, n_gnt_ready);
        end
        tick();
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        #1;
        checks++;
        if ({n_fin_valid, n_fin_dst, n_fin_mxid} !== {1'b1, 2'd2, 2'd1}) begin
            errors++;
            $display("FAIL flush_next got v=%b dst=%0d xid=%0d expected 1/2/1",
                     n_fin_valid, n_fin_dst, n_fin_mxid);
        end
        n_fin_ready = 1'b1;
        tick();
    endtask

    initial begin
        reset = 1'b1; exp_fin = 1'b0;
        c_acq_valid = 0; c_acq_block = 0; c_acq_xid = 0; c_acq_beat = 0; c_acq_builtin = 0;
        c_acq_type = 0; c_acq_union = 0; c_acq_data = 0;
        c_rel_valid = 0; c_rel_beat = 0; c_rel_block = 0; c_rel_xid = 0; c_rel_vol = 0;
        c_rel_type = 0; c_rel_data = 0;
        c_gnt_ready = 1'b1; c_prb_ready = 0;
        n_acq_ready = 0; n_rel_ready = 0; n_fin_ready = 0;
        n_gnt_dst = 2'd0;
        n_prb_valid = 0; n_prb_src = 0; n_prb_dst = 0; n_prb_block = 0; n_prb_type = 0;
        drive_grant(1'b0, 1'b0, 4'd0, 3'd0, 2'd0, 2'd0, 1'b0);
        @(negedge clk);
        test_reset();
        test_acquire_release();
        test_probe();
        test_put_ack();
        test_multibeat();
        test_voluntary();
        test_full();
        test_reset_flush();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_empty got %0d pending expected 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
